// File: rtl/maxpool_pkg.sv
// ---------------------------------------------------------------------------
// maxpool_pkg
// Shared types and helpers for the streaming binary max-pool.
//   out_dim()     : pooled dimension for a given input size and pool/stride
//                   (trailing pixels that do not fill a window are dropped)
//   used_dim()    : number of input pixels/rows that contribute to the output
//   mp_state_t    : output register state (FILL = empty, HOLD = row held)
// ---------------------------------------------------------------------------
package maxpool_pkg;

   // Window size and stride are equal, so any remainder is simply dropped.
   function automatic int out_dim(input int in_dim, input int pool);
      return in_dim / pool;
   endfunction

   // Input extent that is actually covered by complete windows.
   function automatic int used_dim(input int in_dim, input int pool);
      return (in_dim / pool) * pool;
   endfunction

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } mp_state_t;

endpackage

// File: rtl/maxpool_row_reduce.sv
// ---------------------------------------------------------------------------
// maxpool_row_reduce
// Combinational horizontal OR-reduction of one input row for all channels.
// Ports:
//   in_row [IC*IMG_IN_W-1:0] : bit c*IMG_IN_W+x is channel c, column x
//   red    [IC*OUT_W-1:0]    : bit c*OUT_W+x is the OR of the POOL columns
//                              x*POOL .. x*POOL+POOL-1 of channel c
// Trailing IMG_IN_W%POOL columns of each channel do not reach the output.
// ---------------------------------------------------------------------------
module maxpool_row_reduce
   import maxpool_pkg::*;
#(
   parameter  int IMG_IN_W = 28,
   parameter  int POOL     = 2,
   parameter  int IC       = 10,
   localparam int OUT_W    = out_dim(IMG_IN_W, POOL)
) (
   input  logic [IC*IMG_IN_W-1:0] in_row,
   output logic [IC*OUT_W-1:0]    red
);

   localparam int TAIL = IMG_IN_W - used_dim(IMG_IN_W, POOL);

   // OR every window of POOL adjacent columns into one pooled column.
   always_comb begin
      red = '0;
      for (int c = 0; c < IC; c++) begin
         for (int x = 0; x < OUT_W; x++) begin
            for (int k = 0; k < POOL; k++) begin
               red[c*OUT_W + x] = red[c*OUT_W + x] | in_row[c*IMG_IN_W + x*POOL + k];
            end
         end
      end
   end

   // Trailing columns are intentionally ignored; fold them into a named sink
   // so that dropping them is visibly deliberate.
   generate
      if (TAIL > 0) begin : g_tail
         logic [IC-1:0] unused_tail;
         for (genvar c = 0; c < IC; c++) begin : g_ch
            assign unused_tail[c] = ^in_row[c*IMG_IN_W + used_dim(IMG_IN_W, POOL) +: TAIL];
         end
      end
   endgenerate

endmodule

// File: rtl/maxpool_stream.sv
// ---------------------------------------------------------------------------
// maxpool_stream
// Row-serial binary max-pool: accepts one input row (all channels) per beat,
// ORs POOLxPOOL windows with stride POOL and emits one pooled row for every
// POOL input rows.  Trailing rows/columns that do not fill a window are
// consumed and dropped.
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : input row handshake (in_ready is combinational)
//   in_row            : bit c*IMG_IN_W+x is channel c, column x
//   out_valid/out_ready : pooled row handshake
//   out_row           : bit c*OUT_W+x is channel c, pooled column x
//   out_last          : marks the final pooled row of a frame
// Optional build macro MAXPOOL_STREAM_FRAME_CHECK_EN adds:
//   in_last           : end-of-frame marker travelling with in_row
//   frame_err         : sticky flag, set when in_last disagrees with the count;
//                       an early in_last also restarts the frame
// ---------------------------------------------------------------------------
module maxpool_stream
   import maxpool_pkg::*;
#(
   parameter  int IMG_IN_W = 28,
   parameter  int IMG_IN_H = 28,
   parameter  int POOL     = 2,
   parameter  int IC       = 10,
   localparam int OUT_W    = out_dim(IMG_IN_W, POOL),
   localparam int OUT_H    = out_dim(IMG_IN_H, POOL)
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef MAXPOOL_STREAM_FRAME_CHECK_EN
   input  logic                   in_last,
   output logic                   frame_err,
`endif
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IC*IMG_IN_W-1:0] in_row,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IC*OUT_W-1:0]    out_row,
   output logic                   out_last
);

   localparam int RC_W      = (IMG_IN_H > 1) ? $clog2(IMG_IN_H) : 1;
   localparam int PH_W      = $clog2(POOL);
   localparam int USED_ROWS = used_dim(IMG_IN_H, POOL);

   localparam logic [RC_W-1:0] LAST_ROW  = RC_W'(IMG_IN_H - 1);
   localparam logic [RC_W-1:0] LAST_USED = RC_W'(USED_ROWS - 1);
   localparam logic [PH_W-1:0] LAST_PH   = PH_W'(POOL - 1);

   mp_state_t           state_q, state_d;
   logic [RC_W-1:0]     row_cnt_q, row_cnt_d;
   logic [PH_W-1:0]     ph_q, ph_d;
   logic [IC*OUT_W-1:0] acc_q, acc_d;
   logic [IC*OUT_W-1:0] out_row_q, out_row_d;
   logic                out_last_q, out_last_d;
   logic [IC*OUT_W-1:0] red;
   logic                accept, emit, in_range, complete, resync;

   maxpool_row_reduce #(
      .IMG_IN_W (IMG_IN_W),
      .POOL     (POOL),
      .IC       (IC)
   ) u_reduce (
      .in_row (in_row),
      .red    (red)
   );

   assign out_valid = (state_q == HOLD);
   assign out_row   = out_row_q;
   assign out_last  = out_last_q;

   // A new row fits whenever the output slot is empty or is being drained.
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;

   // Rows past the last complete window band are swallowed without output.
   assign in_range  = int'(row_cnt_q) < USED_ROWS;
   assign complete  = accept && in_range && (ph_q == LAST_PH);

`ifdef MAXPOOL_STREAM_FRAME_CHECK_EN
   logic frame_err_q, frame_err_d;

   assign frame_err = frame_err_q;
   assign resync    = accept && in_last && (row_cnt_q != LAST_ROW);

   // Sticky: any accepted row whose marker disagrees with the count flags it.
   always_comb begin
      frame_err_d = frame_err_q;
      if (accept && (in_last != (row_cnt_q == LAST_ROW))) begin
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) frame_err_q <= 1'b0;
      else     frame_err_q <= frame_err_d;
   end
`else
   assign resync = 1'b0;
`endif

   // Row counter, phase counter and vertical accumulator.  The phase counter
   // restarts with the row counter so a frame height that is not a multiple
   // of POOL still starts each frame at phase 0.
   always_comb begin
      row_cnt_d = row_cnt_q;
      ph_d      = ph_q;
      acc_d     = acc_q;
      if (accept) begin
         if ((row_cnt_q == LAST_ROW) || resync) begin
            row_cnt_d = '0;
            ph_d      = '0;
         end else begin
            row_cnt_d = row_cnt_q + RC_W'(1);
            ph_d      = (ph_q == LAST_PH) ? '0 : ph_q + PH_W'(1);
         end
         if (resync || complete || !in_range) begin
            acc_d = '0;
         end else if (ph_q == '0) begin
            acc_d = red;
         end else begin
            acc_d = acc_q | red;
         end
      end
   end

   // Output slot: a completing row always (re)loads it, so a drain and a
   // completion in the same cycle keep out_valid high with no bubble.
   always_comb begin
      state_d    = state_q;
      out_row_d  = out_row_q;
      out_last_d = out_last_q;
      if (complete) begin
         state_d    = HOLD;
         out_row_d  = acc_q | red;
         out_last_d = (row_cnt_q == LAST_USED);
      end else if (emit) begin
         state_d    = FILL;
         out_last_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         row_cnt_q  <= '0;
         ph_q       <= '0;
         acc_q      <= '0;
         out_row_q  <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_cnt_q  <= row_cnt_d;
         ph_q       <= ph_d;
         acc_q      <= acc_d;
         out_row_q  <= out_row_d;
         out_last_q <= out_last_d;
      end
   end

endmodule
